// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment scanner: hex decode, decimal points,
// per-digit enable/blink, and an all-off dead window at the start of each digit slot.
module seg_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1600,
  parameter int DEAD_CYCLES = 16,
  parameter int BLINK_TICKS = 200
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int DEAD_W  = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [DEAD_W-1:0]  DEAD_INIT  = DEAD_W'(DEAD_CYCLES);

  logic [DIV_W-1:0]      r_divCnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DEAD_W-1:0]     r_deadCnt;
  logic [BLINK_W-1:0]    r_blinkCnt;
  logic                  r_phase;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frameTick;

  logic                  w_tick;
  logic                  w_lastIdx;
  logic [3:0]            w_nib;
  logic [6:0]            w_code;
  logic                  w_visible;
  logic [NUM_DIGITS-1:0] w_anNext;

  assign w_tick    = (r_divCnt == DIV_LAST);
  assign w_lastIdx = (r_idx == IDX_LAST);
  assign w_nib     = digits[{r_idx, 2'b00} +: 4];
  assign w_visible = !(blink_en[r_idx] && !r_phase);

  // Active-low g..a patterns for the full hex range
  always_comb begin
    w_code = 7'h7F;
    case (w_nib)
      4'h0: w_code = 7'h40;
      4'h1: w_code = 7'h79;
      4'h2: w_code = 7'h24;
      4'h3: w_code = 7'h30;
      4'h4: w_code = 7'h19;
      4'h5: w_code = 7'h12;
      4'h6: w_code = 7'h02;
      4'h7: w_code = 7'h78;
      4'h8: w_code = 7'h00;
      4'h9: w_code = 7'h10;
      4'hA: w_code = 7'h08;
      4'hB: w_code = 7'h03;
      4'hC: w_code = 7'h46;
      4'hD: w_code = 7'h21;
      4'hE: w_code = 7'h06;
      4'hF: w_code = 7'h0E;
      default: w_code = 7'h7F;
    endcase
  end

  always_comb begin
    w_anNext = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i) && digit_en[i]) w_anNext[i] = 1'b0;
    end
  end

  // Outputs are computed from the current scan state, so they trail it by one clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_divCnt    <= '0;
      r_idx       <= '0;
      r_deadCnt   <= DEAD_INIT;
      r_blinkCnt  <= '0;
      r_phase     <= 1'b1;
      r_seg       <= 8'hFF;
      r_an        <= '1;
      r_frameTick <= 1'b0;
    end else begin
      r_divCnt    <= w_tick ? '0 : r_divCnt + 1'b1;
      r_frameTick <= w_tick && w_lastIdx;
      if (w_tick) begin
        r_idx     <= w_lastIdx ? '0 : r_idx + 1'b1;
        r_deadCnt <= DEAD_INIT;
        if (r_blinkCnt == BLINK_LAST) begin
          r_blinkCnt <= '0;
          r_phase    <= ~r_phase;
        end else begin
          r_blinkCnt <= r_blinkCnt + 1'b1;
        end
      end else if (r_deadCnt != '0) begin
        r_deadCnt <= r_deadCnt - 1'b1;
      end
      if (r_deadCnt != '0) begin
        r_seg <= 8'hFF;
        r_an  <= '1;
      end else begin
        r_seg <= w_visible ? {~dp[r_idx], w_code} : 8'hFF;
        r_an  <= w_anNext;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIV=10, two dead clocks and four-tick blink.
module tb_seg_scan_display;

  logic        clock;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digitEn;
  logic [3:0]  blinkEn;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frameTick;

  int vecCount;
  int missCount;
  int n;
  logic [7:0] slotSeg [4];
  bit useSlotTable;

  seg_scan_display #(
    .NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYCLES(2), .BLINK_TICKS(4)
  ) dut (
    .clock(clock), .reset(reset), .digits(digits), .dp(dp),
    .digit_en(digitEn), .blink_en(blinkEn),
    .seg(seg), .an(an), .frame_tick(frameTick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", tag, observed, expected, n);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] en, input logic [3:0] bl);
    digits  = d;
    dp      = p;
    digitEn = en;
    blinkEn = bl;
  endtask

  function automatic logic [6:0] hexCode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected {frame_tick, an, seg} after cycle k clocks past reset release
  function automatic logic [12:0] expOut(input int k);
    int m, r, s, idx;
    logic ph;
    logic [3:0] one;
    logic [3:0] expAn;
    logic [7:0] expSeg;
    logic expFrame;
    one = 4'b0001;
    expAn = 4'hF;
    expSeg = 8'hFF;
    expFrame = 1'b0;
    if (k > 0) begin
      m = k - 1;
      r = m % 10;
      s = m / 10;
      idx = s % 4;
      ph = ((s / 4) % 2) == 0;
      expFrame = (k % 40) == 0;
      if (r >= 2) begin
        expAn  = digitEn[idx] ? ~(one << idx) : 4'hF;
        expSeg = (blinkEn[idx] && !ph) ? 8'hFF : {~dp[idx], hexCode(digits[idx*4 +: 4])};
      end
    end
    return {expFrame, expAn, expSeg};
  endfunction

  task automatic runCycles(input string tag, input int count);
    logic [12:0] e;
    int m;
    for (int c = 0; c < count; c++) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      e = expOut(n);
      checkOutput({tag, ".seg"}, {8'h00, seg}, {8'h00, e[7:0]});
      checkOutput({tag, ".an"}, {12'h000, an}, {12'h000, e[11:8]});
      checkOutput({tag, ".frame"}, {15'h0, frameTick}, {15'h0, e[12]});
      checkOutput({tag, ".oneCold"}, {15'h0, ($countones(~an) <= 1)}, 16'h0001);
      m = n - 1;
      if (useSlotTable && (m % 10) >= 2)
        checkOutput({tag, ".table"}, {8'h00, seg}, {8'h00, slotSeg[(m / 10) % 4]});
    end
  endtask

  task automatic runUntil(input string tag, input int target);
    for (int c = 0; c < 40 && (n % 40) != target; c++) runCycles(tag, 1);
  endtask

  task automatic asyncResetCheck(input string tag, input int holdClocks);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput({tag, ".rstSeg"}, {8'h00, seg}, 16'h00FF);
    checkOutput({tag, ".rstAn"}, {12'h000, an}, 16'h000F);
    checkOutput({tag, ".rstFrame"}, {15'h0, frameTick}, 16'h0000);
    repeat (holdClocks) @(posedge clock);
    #3 reset = 1'b0;
    n = 0;
  endtask

  initial begin
    vecCount = 0;
    missCount = 0;
    n = 0;
    useSlotTable = 1'b0;
    reset = 1'b1;
    applyStimulus(16'h1234, 4'b0000, 4'b1111, 4'b0000);
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    checkOutput("reset.seg", {8'h00, seg}, 16'h00FF);
    checkOutput("reset.an", {12'h000, an}, 16'h000F);

    slotSeg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    useSlotTable = 1'b1;
    runCycles("t1", 80);

    applyStimulus(16'hFEDA, 4'b0001, 4'b1111, 4'b0000);
    slotSeg = '{8'h08, 8'hA1, 8'h86, 8'h8E};
    runCycles("t2", 40);
    useSlotTable = 1'b0;

    applyStimulus(16'h1234, 4'b0000, 4'b1111, 4'b0100);
    runCycles("t3", 160);

    applyStimulus(16'h1234, 4'b0000, 4'b1011, 4'b0000);
    runCycles("t4", 40);

    applyStimulus(16'h1234, 4'b0000, 4'b1111, 4'b0000);
    runUntil("t5", 5);
    asyncResetCheck("t5lit", 3);
    runCycles("t5", 45);

    runUntil("t6", 20);
    asyncResetCheck("t6", 3);
    runCycles("t6", 45);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
